pwm_meas: RTL
=============

Name: pwm_meas

Overview:
- Receive-side counterpart to the team's PWM generator.
- Samples an asynchronous PWM input and measures period and high time in clk cycles between successive rising edges.
- Publishes each completed measurement with a one-cycle valid strobe, and flags a stuck-high or stuck-low input via a programmable timeout.
- Used for loopback checking of PWM outputs and for decoding external PWM sensors.

Parameters:
- W, 32, width of period/high counters, outputs and timeout.
- SYNC_STAGES, 2, input synchronizer flops (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- pwm_in  in  1  asynchronous PWM input.
- en  in  1  measurement enable.
- timeout  in  W  max cycles without a rising edge before stuck is flagged; 0 disables the timeout.
- period_out  out  W  last measured period, in cycles.
- high_out  out  W  last measured high time, in cycles.
- meas_valid  out  1  one-cycle strobe when period_out/high_out update.
- stuck_high  out  1  timeout expired with input high.
- stuck_low  out  1  timeout expired with input low.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async): synchronizer, edge-history flop, counters, period_out, high_out, meas_valid, stuck_high, stuck_low and busy all 0. FSM goes to IDLE.
- Synchronizer: pwm_in passes through SYNC_STAGES flops, giving s. Flop p holds the previous s.
  - rise = s & ~p
  - fall = ~s & p
- FSM states: IDLE, HIGH, LOW.
  - IDLE: counters idle. On rise with en=1: pcnt<=1, hcnt<=1, go HIGH.
  - HIGH, no edge: pcnt+1 and hcnt+1 each cycle. On fall: pcnt+1, hcnt holds, go LOW.
  - LOW, no edge: pcnt+1 each cycle, hcnt holds.
  - LOW on rise: period_out<=pcnt, high_out<=hcnt, meas_valid<=1, stuck_high<=0, stuck_low<=0. Then pcnt<=1, hcnt<=1, go HIGH (back-to-back measurement).
- Resulting values: an input high for H cycles then low for L cycles gives period_out=H+L and high_out=H.
- Output timing: meas_valid is registered. It is high exactly one cycle, the cycle after rise is seen on s. period_out/high_out change only in that same cycle and hold otherwise.
- Latency: a pin rising edge produces meas_valid SYNC_STAGES+1 clocks later, ±1 cycle sampling uncertainty.
- First measurement: the first rise after IDLE only starts counting. No meas_valid until the second rise.
- Timeout: when timeout!=0 and, in HIGH or LOW, the next pcnt value would exceed timeout:
  - set stuck_high<=s and stuck_low<=~s;
  - no meas_valid; period_out/high_out hold;
  - go IDLE.
  - Flags are sticky. They clear only on the next meas_valid or on reset.
- Counter saturation: pcnt and hcnt saturate at all-ones and never wrap. This only matters with timeout=0.
- en=0: FSM returns to IDLE on the next clock with no meas_valid. Outputs and flags hold. The synchronizer keeps running.
  - If en rises while s is already high, measurement starts at the next genuine rise only.
- Simultaneous events:
  - rise and timeout in the same cycle: rise wins (valid measurement, no flag).
  - en=0 and rise in the same cycle: en=0 wins.
- A pulse shorter than one clk may be missed. Glitches that survive the synchronizer are measured as real edges. No debounce.
- Reset mid-measurement discards the partial counts.

Test Plan:
- Reset, en=1, pwm_in 30 cycles high / 70 low for 4 periods → meas_valid pulses once per period starting at the 2nd rise; period_out=100, high_out=30; stuck flags 0.
- Duty step: 30/70 then 80/20 → outputs 100/30 then 100/80. No stray valid at the transition. Each meas_valid is exactly 1 cycle wide.
- timeout=50, pwm_in held high after a rise → stuck_high=1 once pcnt would reach 51; busy=0; no meas_valid. Then resume 10/10 → after 2 rises meas_valid with 20/10 and stuck_high cleared. Repeat held low → stuck_low.
- en dropped to 0 mid-LOW → IDLE next cycle, no meas_valid, period_out/high_out unchanged. en re-asserted with input high → first output only after two new rises.
- Minimal pulse: 1 high / 1 low cycles → period_out=2, high_out=1 every 2 cycles. Also timeout=0 with input static: no flags, busy stays 1 and counters saturate.
- Async rst asserted mid-HIGH → all outputs 0 immediately. After release, behaves as from first rise.

Source files
------------

// File: rtl/pwm_meas.sv
// pwm_meas: measures period and high time (in clk cycles) of an asynchronous
// PWM input between successive rising edges, and flags a stuck input.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   pwm_in     asynchronous PWM input
//   en         measurement enable
//   timeout    max cycles without a rising edge before stuck is flagged (0 = off)
//   period_out last measured period
//   high_out   last measured high time
//   meas_valid one-cycle strobe when period_out/high_out update
//   stuck_high timeout expired with input high (sticky until next measurement)
//   stuck_low  timeout expired with input low (sticky until next measurement)
//   busy       measurement in progress (FSM not idle)
module pwm_meas #(
  parameter int unsigned W           = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm_in,
  input  logic         en,
  input  logic [W-1:0] timeout,
  output logic [W-1:0] period_out,
  output logic [W-1:0] high_out,
  output logic         meas_valid,
  output logic         stuck_high,
  output logic         stuck_low,
  output logic         busy
);

  // Fewer than two stages is not a safe synchronizer; clamp silently.
  localparam int unsigned NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  logic [NSYNC-1:0] sync_q, sync_d;
  logic             p_q, p_d;
  logic             s, rise, fall;

  state_e           state_q, state_d;
  logic [W-1:0]     pcnt_q, pcnt_d;
  logic [W-1:0]     hcnt_q, hcnt_d;
  logic [W-1:0]     period_q, period_d;
  logic [W-1:0]     high_q, high_d;
  logic             valid_q, valid_d;
  logic             stuck_high_q, stuck_high_d;
  logic             stuck_low_q, stuck_low_d;
  logic             busy_q, busy_d;

  logic [W-1:0]     pcnt_inc, hcnt_inc;
  logic             timeout_hit;

  // Synchronizer shift and previous-sample history for edge detection
  always_comb begin
    sync_d = {sync_q[NSYNC-2:0], pwm_in};
    p_d    = s;
  end

  assign s    = sync_q[NSYNC-1];
  assign rise = s & ~p_q;
  assign fall = ~s & p_q;

  // Saturating increments; counters stick at all-ones instead of wrapping
  assign pcnt_inc    = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + W'(1);
  assign hcnt_inc    = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + W'(1);
  assign timeout_hit = (timeout != '0) && (pcnt_inc > timeout);

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    hcnt_d       = hcnt_q;
    period_d     = period_q;
    high_d       = high_q;
    valid_d      = 1'b0;
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;

    if (!en) begin
      // Disable beats any edge in the same cycle; partial counts are dropped.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            pcnt_d  = W'(1);
            hcnt_d  = W'(1);
            state_d = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (timeout_hit) begin
            stuck_high_d = s;
            stuck_low_d  = ~s;
            state_d      = ST_IDLE;
          end else if (fall) begin
            pcnt_d  = pcnt_inc;
            state_d = ST_LOW;
          end else begin
            pcnt_d = pcnt_inc;
            hcnt_d = hcnt_inc;
          end
        end
        ST_LOW: begin
          // A rise closes the period even if the timeout expires this cycle.
          if (rise) begin
            period_d     = pcnt_q;
            high_d       = hcnt_q;
            valid_d      = 1'b1;
            stuck_high_d = 1'b0;
            stuck_low_d  = 1'b0;
            pcnt_d       = W'(1);
            hcnt_d       = W'(1);
            state_d      = ST_HIGH;
          end else if (timeout_hit) begin
            stuck_high_d = s;
            stuck_low_d  = ~s;
            state_d      = ST_IDLE;
          end else begin
            pcnt_d = pcnt_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      p_q          <= 1'b0;
      state_q      <= ST_IDLE;
      pcnt_q       <= '0;
      hcnt_q       <= '0;
      period_q     <= '0;
      high_q       <= '0;
      valid_q      <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      p_q          <= p_d;
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      hcnt_q       <= hcnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      valid_q      <= valid_d;
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
      busy_q       <= busy_d;
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign meas_valid = valid_q;
  assign stuck_high = stuck_high_q;
  assign stuck_low  = stuck_low_q;
  assign busy       = busy_q;

endmodule
